axi_mem_slave: RTL

AXI4 responder (slave-side RTL) backed by a register-array memory. It accepts write bursts on AW/W and answers on B, and accepts read bursts on AR and answers on R. Used as the downstream endpoint behind the crossbar in block and system benches, so master-side agents have a real target. Write and read paths are independent FSMs sharing one memory array.

---
 rtl/axi_typedef_pkg.sv | 38 +++
 rtl/axi_burst_addr_gen.sv | 34 +++
 rtl/axi_mem_slave.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_typedef_pkg.sv
// Shared AXI4 field types, burst/response encodings and FSM states.
// Used by axi_mem_slave and axi_burst_addr_gen.
package axi_typedef_pkg;

  typedef logic [7:0] len_t;
  typedef logic [2:0] size_t;
  typedef logic [1:0] burst_t;
  typedef logic [1:0] resp_t;
  typedef logic [5:0] atop_t;
  typedef logic [3:0] cache_t;
  typedef logic [2:0] prot_t;
  typedef logic [3:0] qos_t;
  typedef logic [3:0] region_t;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;
  localparam burst_t BURST_RSVD  = 2'b11;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  function automatic logic wrap_len_ok(len_t len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI4 next-beat address for FIXED/INCR/WRAP bursts.
// Ports: addr_i/len_i/size_i/burst_i in, next_addr_o out.
module axi_burst_addr_gen
  import axi_typedef_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic [AW-1:0] addr_i,
  input  len_t          len_i,
  input  size_t         size_i,
  input  burst_t        burst_i,
  output logic [AW-1:0] next_addr_o
);

  logic [AW-1:0] step;
  logic [AW-1:0] aligned;
  logic [AW-1:0] incr;
  logic [AW-1:0] wmask;

  always_comb begin
    step    = AW'(1) << size_i;
    // Aligning first makes an unaligned INCR start snap to the grid.
    aligned = addr_i & ~(step - AW'(1));
    incr    = aligned + step;
    wmask   = ((AW'(len_i) + AW'(1)) << size_i) - AW'(1);
    next_addr_o = addr_i;
    unique case (burst_i)
      BURST_INCR: next_addr_o = incr;
      BURST_WRAP: next_addr_o = (addr_i & ~wmask) | (incr & wmask);
      default:    next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 responder over a register-array memory; independent write/read FSMs.
// Ports: AW/W/B and AR/R channels; `AXI_MEM_SLAVE_USER_ECHO_EN echoes user bits.
module axi_mem_slave
  import axi_typedef_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter int unsigned MEM_DEPTH      = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ID_WIDTH-1:0]   aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
  input  len_t                      aw_len,
  input  size_t                     aw_size,
  input  burst_t                    aw_burst,
  input  atop_t                     aw_atop,
  input  logic [AXI_USER_WIDTH-1:0] aw_user,
  input  logic                      aw_lock,
  input  cache_t                    aw_cache,
  input  prot_t                     aw_prot,
  input  qos_t                      aw_qos,
  input  region_t                   aw_region,
  input  logic                      aw_valid,
  output logic                      aw_ready,
  input  logic [AXI_DATA_WIDTH-1:0] w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
  input  logic                      w_last,
  input  logic [AXI_USER_WIDTH-1:0] w_user,
  input  logic                      w_valid,
  output logic                      w_ready,
  output logic [AXI_ID_WIDTH-1:0]   b_id,
  output resp_t                     b_resp,
  output logic [AXI_USER_WIDTH-1:0] b_user,
  output logic                      b_valid,
  input  logic                      b_ready,
  input  logic [AXI_ID_WIDTH-1:0]   ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
  input  len_t                      ar_len,
  input  size_t                     ar_size,
  input  burst_t                    ar_burst,
  input  logic [AXI_USER_WIDTH-1:0] ar_user,
  input  logic                      ar_lock,
  input  cache_t                    ar_cache,
  input  prot_t                     ar_prot,
  input  qos_t                      ar_qos,
  input  region_t                   ar_region,
  input  logic                      ar_valid,
  output logic                      ar_ready,
  output logic [AXI_ID_WIDTH-1:0]   r_id,
  output logic [AXI_DATA_WIDTH-1:0] r_data,
  output resp_t                     r_resp,
  output logic                      r_last,
  output logic [AXI_USER_WIDTH-1:0] r_user,
  output logic                      r_valid,
  input  logic                      r_ready
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  // MEM_DEPTH is a power of two, so the modulo is a plain slice.
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(STRB_W);

  typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
  typedef logic [AXI_DATA_WIDTH-1:0] data_t;

  function automatic logic [IDX_W-1:0] widx(addr_t a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic oob(addr_t a);
    return 64'(a) >= MEM_BYTES;
  endfunction

  function automatic logic req_err(
    addr_t a, len_t l, size_t s, burst_t b
  );
    return oob(a) || (s > size_t'(OFF_W)) ||
           (b == BURST_WRAP && !wrap_len_ok(l)) ||
           (b == BURST_RSVD);
  endfunction

  data_t mem_q [MEM_DEPTH];

  wstate_e w_state_q, w_state_d;
  logic [AXI_ID_WIDTH-1:0] wid_q, wid_d;
  addr_t  waddr_q, waddr_d, waddr_nxt;
  len_t   wlen_q, wlen_d, wcnt_q, wcnt_d;
  size_t  wsize_q, wsize_d;
  burst_t wburst_q, wburst_d;
  logic   werr_q, werr_d;
  logic   mem_we, w_oob, w_lastbeat;

  rstate_e r_state_q, r_state_d;
  logic [AXI_ID_WIDTH-1:0] rid_q, rid_d;
  addr_t  raddr_q, raddr_d, raddr_nxt;
  len_t   rlen_q, rlen_d, rcnt_q, rcnt_d;
  size_t  rsize_q, rsize_d;
  burst_t rburst_q, rburst_d;
  logic   rerr_q, rerr_d, r_nxt_oob;
  data_t  rdata_q, rdata_d;
  logic   rlast_q, rlast_d;

  axi_burst_addr_gen #(.AW(AXI_ADDR_WIDTH)) u_wgen (
    .addr_i(waddr_q), .len_i(wlen_q), .size_i(wsize_q),
    .burst_i(wburst_q), .next_addr_o(waddr_nxt)
  );

  axi_burst_addr_gen #(.AW(AXI_ADDR_WIDTH)) u_rgen (
    .addr_i(raddr_q), .len_i(rlen_q), .size_i(rsize_q),
    .burst_i(rburst_q), .next_addr_o(raddr_nxt)
  );

  always_comb begin
    w_state_d  = w_state_q;
    wid_d      = wid_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wsize_d    = wsize_q;
    wburst_d   = wburst_q;
    werr_d     = werr_q;
    wcnt_d     = wcnt_q;
    mem_we     = 1'b0;
    w_oob      = oob(waddr_q);
    w_lastbeat = (wcnt_q == wlen_q);
    unique case (w_state_q)
      W_IDLE: if (aw_valid) begin
        wid_d     = aw_id;
        waddr_d   = aw_addr;
        wlen_d    = aw_len;
        wsize_d   = aw_size;
        wburst_d  = aw_burst;
        wcnt_d    = '0;
        werr_d    = req_err(aw_addr, aw_len, aw_size, aw_burst) ||
                    (aw_atop != '0);
        w_state_d = W_DATA;
      end
      W_DATA: if (w_valid) begin
        // A beat past the memory top is dropped and flags the burst.
        mem_we  = !werr_q && !w_oob;
        werr_d  = werr_q || w_oob || (w_last != w_lastbeat);
        waddr_d = waddr_nxt;
        wcnt_d  = wcnt_q + 8'd1;
        if (w_lastbeat) w_state_d = W_RESP;
      end
      W_RESP: if (b_ready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= BURST_FIXED;
      werr_q    <= 1'b0;
      wcnt_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      werr_q    <= werr_d;
      wcnt_q    <= wcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb[b]) mem_q[widx(waddr_q)][b*8 +: 8] <= w_data[b*8 +: 8];
      end
    end
  end

  // Read data is registered at the handshake, so a same-cycle write
  // to the same word is not visible in this beat.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rerr_d    = rerr_q;
    rcnt_d    = rcnt_q;
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;
    r_nxt_oob = oob(raddr_nxt);
    unique case (r_state_q)
      R_IDLE: if (ar_valid) begin
        rid_d     = ar_id;
        raddr_d   = ar_addr;
        rlen_d    = ar_len;
        rsize_d   = ar_size;
        rburst_d  = ar_burst;
        rcnt_d    = '0;
        rerr_d    = req_err(ar_addr, ar_len, ar_size, ar_burst);
        rdata_d   = rerr_d ? '0 : mem_q[widx(ar_addr)];
        rlast_d   = (ar_len == '0);
        r_state_d = R_DATA;
      end
      R_DATA: if (r_ready) begin
        if (rlast_q) begin
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          raddr_d = raddr_nxt;
          rcnt_d  = rcnt_q + 8'd1;
          rerr_d  = rerr_q || r_nxt_oob;
          rdata_d = rerr_d ? '0 : mem_q[widx(raddr_nxt)];
          rlast_d = (rcnt_d == rlen_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= BURST_FIXED;
      rerr_q    <= 1'b0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rerr_q    <= rerr_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      rlast_q   <= rlast_d;
    end
  end

  assign aw_ready = (w_state_q == W_IDLE);
  assign w_ready  = (w_state_q == W_DATA);
  assign b_valid  = (w_state_q == W_RESP);
  assign b_id     = wid_q;
  assign b_resp   = werr_q ? RESP_SLVERR : RESP_OKAY;

  assign ar_ready = (r_state_q == R_IDLE);
  assign r_valid  = (r_state_q == R_DATA);
  assign r_id     = rid_q;
  assign r_data   = rdata_q;
  assign r_last   = rlast_q;
  assign r_resp   = rerr_q ? RESP_SLVERR : RESP_OKAY;

`ifdef AXI_MEM_SLAVE_USER_ECHO_EN
  logic [AXI_USER_WIDTH-1:0] wuser_q, ruser_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wuser_q <= '0;
      ruser_q <= '0;
    end else begin
      if (aw_valid && aw_ready) wuser_q <= aw_user;
      if (ar_valid && ar_ready) ruser_q <= ar_user;
    end
  end

  assign b_user = wuser_q;
  assign r_user = ruser_q;

  logic unused_sb;
  assign unused_sb = ^{aw_lock, aw_cache, aw_prot, aw_qos, aw_region,
                       ar_lock, ar_cache, ar_prot, ar_qos, ar_region,
                       w_user};
`else
  assign b_user = '0;
  assign r_user = '0;

  logic unused_sb;
  assign unused_sb = ^{aw_lock, aw_cache, aw_prot, aw_qos, aw_region,
                       ar_lock, ar_cache, ar_prot, ar_qos, ar_region,
                       w_user, aw_user, ar_user};
`endif

endmodule
